// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder: valid/ready on the
// operand side and on the result side.
interface pipelined_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into
// SLICE-bit slices with a register stage after each slice.
module pipelined_adder #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);
   localparam int STAGES = WIDTH / SLICE;

   if (WIDTH % SLICE != 0) begin : g_param_check
      $fatal(1, "pipelined_adder: WIDTH must be a multiple of SLICE");
   end

   // One enable for every stage: the whole pipe moves or the whole pipe holds.
   logic adv;
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];
   logic             ovf_q   [STAGES];
   logic             valid_q [STAGES];

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] sum_src;
      logic             carry_src;
      logic             valid_src;
      logic [WIDTH-1:0] sum_d;
      logic             ovf_d;
      logic [SLICE:0]   slice_sum;

      if (i == 0) begin : g_head
         // Subtract folds into add: invert b here, force the carry-in to 1.
         assign a_src     = bus.a;
         assign b_src     = bus.sub ? ~bus.b : bus.b;
         assign carry_src = bus.sub | bus.cin;
         assign sum_src   = '0;
         assign valid_src = bus.in_valid;
      end else begin : g_body
         assign a_src     = a_q[i-1];
         assign b_src     = b_q[i-1];
         assign carry_src = carry_q[i-1];
         assign sum_src   = sum_q[i-1];
         assign valid_src = valid_q[i-1];
      end

      assign slice_sum = {1'b0, a_src[i*SLICE +: SLICE]}
                       + {1'b0, b_src[i*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, carry_src};

      // Carry into the slice MSB is a^b^s at that bit; only the top slice's value reaches ovf.
      assign ovf_d = a_src[i*SLICE + SLICE-1] ^ b_src[i*SLICE + SLICE-1]
                   ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];

      always_comb begin
         // NOTE: full default first, then overwrite one slice -- no path leaves sum_d unassigned, so no latch.
         sum_d                    = sum_src;
         sum_d[i*SLICE +: SLICE]  = slice_sum[SLICE-1:0];
      end

      always_ff @(posedge clk) begin
         // NOTE: non-blocking updates so every stage samples its predecessor's pre-edge value.
         if (!rst_n) begin
            a_q[i]     <= '0;
            b_q[i]     <= '0;
            sum_q[i]   <= '0;
            carry_q[i] <= 1'b0;
            ovf_q[i]   <= 1'b0;
            valid_q[i] <= 1'b0;
         end else if (adv) begin
            a_q[i]     <= a_src;
            b_q[i]     <= b_src;
            sum_q[i]   <= sum_d;
            carry_q[i] <= slice_sum[SLICE];
            ovf_q[i]   <= ovf_d;
            valid_q[i] <= valid_src;
         end
      end
   end

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.s         = sum_q[STAGES-1];
   assign bus.cout      = carry_q[STAGES-1];
   assign bus.ovf       = ovf_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors, stall, reset and random streams
// on an 8/4 and a 32/8 instance, results compared in order.
module tb_pipelined_adder;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [33:0] exp;   // {cout, ovf, s}
   } op_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(8))  bus8  ();
   pipelined_adder_if #(.WIDTH(32)) bus32 ();

   pipelined_adder #(.WIDTH(8),  .SLICE(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   pipelined_adder #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   int          n_checks = 0;
   int          n_errors = 0;
   op_t         op_q [$];
   logic [33:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic op_t vec(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, input logic cout, input logic ovf,
                               input logic [31:0] s);
      op_t o;
      o.a = a; o.b = b; o.cin = cin; o.sub = sub; o.exp = {cout, ovf, s};
      return o;
   endfunction

   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      logic [31:0] mask, am, bm, s;
      logic [32:0] full;
      logic        co, ov;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      am   = a & mask;
      bm   = (sub ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bm} + {32'd0, (sub | cin)};
      s    = full[31:0] & mask;
      co   = full[w];
      ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {co, ov, s};
   endfunction

   task automatic drive(input int sel, input logic iv, input op_t op, input logic ordy);
      if (sel == 0) begin
         bus8.in_valid = iv;  bus8.a = op.a[7:0]; bus8.b = op.b[7:0];
         bus8.cin = op.cin;   bus8.sub = op.sub;  bus8.out_ready = ordy;
      end else begin
         bus32.in_valid = iv; bus32.a = op.a;     bus32.b = op.b;
         bus32.cin = op.cin;  bus32.sub = op.sub; bus32.out_ready = ordy;
      end
   endtask

   task automatic sample(input int sel, output logic ir, output logic ov, output logic [33:0] res);
      if (sel == 0) begin
         ir = bus8.in_ready; ov = bus8.out_valid; res = {bus8.cout, bus8.ovf, 24'd0, bus8.s};
      end else begin
         ir = bus32.in_ready; ov = bus32.out_valid; res = {bus32.cout, bus32.ovf, bus32.s};
      end
   endtask

   // Streams op_q through one DUT. mode 0: full rate, 1: random valid/ready,
   // 2: out_ready low on cycles 4..6. Entered and left at posedge+1.
   task automatic run(input int sel, input int mode, input int stages, input int max_cycles);
      int          cyc, idle;
      logic        iv, ordy, ir, ov, held;
      logic [33:0] res, held_val;
      op_t         cur;
      cyc = 0; idle = 0; held = 1'b0; held_val = '0;
      while (1) begin
         if (cyc >= max_cycles) begin
            check("timeout_pending", op_q.size() + exp_q.size(), 0);
            break;
         end
         if (op_q.size() == 0 && exp_q.size() == 0) begin
            idle++;
            if (idle > stages + 1) break;
         end
         iv   = (op_q.size() > 0) && (mode != 1 || $urandom_range(3) != 0);
         ordy = (mode == 1) ? ($urandom_range(1) == 1) :
                (mode == 2) ? !(cyc >= 4 && cyc < 7) : 1'b1;
         cur  = (op_q.size() > 0) ? op_q[0] : '0;
         drive(sel, iv, cur, ordy);
         #1;
         sample(sel, ir, ov, res);
         if (held) check("stall_hold", {ov, res}, {1'b1, held_val});
         held     = ov && !ordy;
         held_val = res;
         if (held) check("stall_in_ready", ir, 0);
         if (ov && ordy) begin
            if (exp_q.size() == 0) check("extra_result", exp_q.size(), 1);
            else                   check("result", res, exp_q.pop_front());
         end
         if (iv && ir) begin
            cur = op_q.pop_front();
            exp_q.push_back(cur.exp);
         end
         @(posedge clk); #1;
         cyc++;
      end
      drive(sel, 1'b0, '0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ir, ov;
      logic [33:0] res;
      op_t         op;

      rst_n = 1'b0;
      drive(0, 1'b0, '0, 1'b1);
      drive(1, 1'b0, '0, 1'b1);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1; #1;
      sample(0, ir, ov, res);
      check("rst_out_valid", ov, 0);
      check("rst_s_cout_ovf", res, 0);
      check("rst_in_ready", ir, 1);
      @(posedge clk); #1;

      // Latency: accepted at edge N, visible after edge N+1, for one cycle.
      op = vec(32'h01, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h02);
      drive(0, 1'b1, op, 1'b1); #1;
      sample(0, ir, ov, res);
      check("lat_accept_ready", ir, 1);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, 1'b1); #1;
      sample(0, ir, ov, res);
      check("lat_edge1_valid", ov, 0);
      @(posedge clk); #1; #1;
      sample(0, ir, ov, res);
      check("lat_edge2_valid", ov, 1);
      check("lat_result", res, op.exp);
      @(posedge clk); #1; #1;
      sample(0, ir, ov, res);
      check("lat_single_cycle", ov, 0);
      @(posedge clk); #1;

      // Directed carry/overflow/subtract vectors, {a, b, cin, sub, cout, ovf, s}.
      op_q.push_back(vec(32'h0F, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10));
      op_q.push_back(vec(32'hFF, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00));
      op_q.push_back(vec(32'h80, 32'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF));
      op_q.push_back(vec(32'h80, 32'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7F));
      op_q.push_back(vec(32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80));
      op_q.push_back(vec(32'h03, 32'h05, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFE));
      op_q.push_back(vec(32'h80, 32'h01, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7F));
      op_q.push_back(vec(32'h05, 32'h05, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00));
      run(0, 0, 2, 200);

      // Six back-to-back ops with a three-cycle output stall mid-stream.
      for (int k = 1; k <= 6; k++)
         op_q.push_back(vec(k * 32'h11, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0, k * 32'h11 + 32'h01));
      run(0, 2, 2, 200);

      for (int k = 0; k < 1000; k++) begin
         op.a = $urandom; op.b = $urandom;
         op.cin = 1'($urandom_range(1)); op.sub = 1'($urandom_range(1));
         op.exp = model(8, op.a, op.b, op.cin, op.sub);
         op_q.push_back(op);
      end
      run(0, 1, 2, 20000);

      for (int k = 0; k < 1000; k++) begin
         op.a = $urandom; op.b = $urandom;
         op.cin = 1'($urandom_range(1)); op.sub = 1'($urandom_range(1));
         op.exp = model(32, op.a, op.b, op.cin, op.sub);
         op_q.push_back(op);
      end
      run(1, 1, 4, 20000);

      // Reset with two ops in flight; neither may ever emerge.
      drive(0, 1'b1, vec(32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33), 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b1, vec(32'h44, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55), 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, '0, 1'b0); #1;
      sample(0, ir, ov, res);
      check("rst_inflight_valid", ov, 1);
      rst_n = 1'b0;
      @(posedge clk); #1; #1;
      sample(0, ir, ov, res);
      check("rst_mid_out_valid", ov, 0);
      check("rst_mid_s_cout_ovf", res, 0);
      check("rst_mid_in_ready", ir, 1);
      rst_n = 1'b1;
      drive(0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #2;
         sample(0, ir, ov, res);
         check("rst_no_ghost", ov, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the fulladder family. Splits the WIDTH-bit carry chain into STAGES slices of SLICE bits, registering between slices, so long adders close timing at full clock rate. Valid/ready streaming handshake on both sides, one result per cycle sustained, add or subtract selected per operation. Produces carry-out and signed overflow.

Parameters:
WIDTH, 8, operand and sum width in bits; must be an integer multiple of SLICE (elaboration-time check, fatal otherwise)
SLICE, 4, bits resolved per pipeline stage; STAGES = WIDTH/SLICE, which is also the latency in cycles

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation present on a/b/cin/sub
in_ready  output  1  block accepts operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used only when sub=0
sub  input  1  0: s=a+b+cin; 1: s=a-b (a+~b+1)
out_valid  output  1  result present on s/cout/ovf
out_ready  input  1  downstream accepts result this cycle
s  output  WIDTH  sum/difference
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a>=b unsigned)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). Pipeline shifts only when adv=1; otherwise every stage register holds.
- Accept: in_valid && in_ready. Stage 1 captures slice 0 result, its carry, valid bit, and skewed remaining operand slices (b pre-inverted when sub=1). Effective carry-in = sub ? 1 : cin.
- Stage k (k=1..STAGES) adds slice k-1 using carry from stage k-1 register; lower result slices propagate alongside. Final stage drives s/cout/ovf/out_valid directly from registers.
- Latency: result of an op accepted at edge N is on outputs after edge N+STAGES-1 (i.e. visible STAGES edges after accept, counting the accept edge), absent stalls. Throughput 1 op/cycle with out_ready held high.
- Bubbles: in_valid=0 on an advancing cycle inserts a bubble (valid=0) that travels through; bubbles are not compressed.
- Stall: out_valid=1 && out_ready=0 freezes all stages and in_ready=0; outputs stable until handshake. No op lost, duplicated, or reordered.
- Simultaneous out handshake and new accept in same cycle: both occur; pipeline shifts once.
- Arithmetic: modulo 2^WIDTH; cout and ovf computed from full-width carry chain, identical to a combinational WIDTH-bit ripple adder.
- Reset (rst_n=0 at edge): all valid bits 0, all data/carry registers 0; s=0, cout=0, ovf=0, out_valid=0. in_ready=1 after reset. Reset mid-operation discards every in-flight op; no output handshake for them.
- STAGES=1 (SLICE=WIDTH) degenerates to a single registered adder, latency 1.

Test Plan:
(WIDTH=8, SLICE=4, latency 2, out_ready=1 unless stated)
- Add 0x01+0x01 cin=0 -> s=0x02 cout=0 ovf=0, out_valid exactly 2 edges after accept, single cycle.
- Cross-slice carry: 0x0F+0x01 -> 0x10 cout0; 0xFF+0x00 cin=1 -> 0x00 cout1 ovf0; 0x80+0x7F -> 0xFF cout0 ovf0; 0x80+0xFF -> 0x7F cout1 ovf1.
- Subtract: 0x03-0x05 -> 0xFE cout0 ovf0; 0x80-0x01 -> 0x7F cout1 ovf1; 0x05-0x05 with cin=1 -> 0x00 cout1 (cin ignored).
- Stream 6 back-to-back ops, drop out_ready for 3 cycles mid-stream -> in_ready low during stall, outputs held, all 6 results in order, none duplicated.
- Random in_valid/out_ready (1000 ops, also WIDTH=32 SLICE=8) vs golden model -> every result matches s/cout/ovf, order preserved.
- Assert rst_n=0 with 2 ops in flight -> next cycle out_valid=0, s=0, in_ready=1; in-flight results never appear.
